// File: rtl/tl_pkg.sv
// Shared transaction-layer definitions.
// Holds the one-hot control state encoding, used by both the control state
// machine and the per-queue FIFOs, together with the threshold and depth sizes.
package tl_pkg;

    // One-hot control state encoding
    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } tl_state_e;

    localparam int TL_THRESH_W   = 3;
    localparam int TL_FIFO_DEPTH = 8;
    localparam int TL_COUNT_W    = 4;

    // Push/pop are honoured only in IDLE or ACTIVE
    function automatic logic tl_op_en(input logic [3:0] state);
        return |(state & (ST_IDLE | ST_ACTIVE));
    endfunction

endpackage

// File: rtl/tl_threshold_fifo_if.sv
// Queue-side handshake bundle for tl_threshold_fifo.
// master: producer/consumer side (drives push/pop/data_in, sees data and status)
// slave : FIFO side
//   push, data_in, pop           - write/read requests
//   data_out, valid_out          - registered read data and its one-cycle strobe
//   count, empty, full           - occupancy
//   almost_full, almost_empty    - threshold flags
//   overflow_err, underflow_err  - sticky error flags
interface tl_threshold_fifo_if #(
    parameter int DATA_WIDTH = 6
);
    import tl_pkg::*;

    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic [TL_COUNT_W-1:0] count;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow_err;
    logic                  underflow_err;

    modport master (
        output push, data_in, pop,
        input  data_out, valid_out, count, empty, full,
               almost_full, almost_empty, overflow_err, underflow_err
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, valid_out, count, empty, full,
               almost_full, almost_empty, overflow_err, underflow_err
    );

endinterface

// File: rtl/tl_fifo_mem.sv
// Register-array storage for tl_threshold_fifo.
// One write port, one registered read port; storage itself is not reset.
//   clk      - clock
//   rd_clr   - synchronous clear of the read data register (reset / INIT flush)
//   wr_en    - write wr_data into wr_addr
//   rd_en    - load rd_data from rd_addr at the next edge; otherwise rd_data holds
module tl_fifo_mem #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rd_clr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Reads see the pre-write array, so a read and write to the same slot
    // (push+pop while full) returns the old entry.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_clr) begin
            rd_data_d = '0;
        end else if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        mem_q     <= mem_d;
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/tl_threshold_fifo.sv
// Synchronous FIFO for one transaction-layer virtual-channel queue.
// Gated by the one-hot control state, flushed in INIT, with almost_full /
// almost_empty compared against the control machine's latched thresholds.
//   clk, reset     - clock, synchronous active-high reset
//   state          - one-hot control state (RESET/INIT/IDLE/ACTIVE)
//   sup_threshold  - almost-full level (0 disables almost_full)
//   inf_threshold  - almost-empty level
//   bus            - push/pop handshake, read data and status flags
module tl_threshold_fifo
    import tl_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             state,
    input  logic [TL_THRESH_W-1:0] sup_threshold,
    input  logic [TL_THRESH_W-1:0] inf_threshold,
    tl_threshold_fifo_if.slave     bus
);

    localparam logic [TL_COUNT_W-1:0] FULL_COUNT = TL_COUNT_W'(TL_FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [TL_COUNT_W-1:0] count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic op_en;
    logic flush;
    logic empty;
    logic full;
    logic pop_acc;
    logic push_acc;

    assign op_en = tl_op_en(state);
    // Reset and INIT clear the same state; reset wins simply by being OR'd in.
    assign flush = reset || (state == ST_INIT);

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

    assign pop_acc  = !flush && op_en && bus.pop && !empty;
    // A pop on a full queue frees a slot in the same cycle.
    assign push_acc = !flush && op_en && bus.push && (!full || pop_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else if (op_en) begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                valid_d  = 1'b1;
            end
            if (push_acc && !pop_acc) begin
                count_d = count_q + 1'b1;
            end else if (pop_acc && !push_acc) begin
                count_d = count_q - 1'b1;
            end
            if (bus.push && full && !pop_acc) begin
                ovf_d = 1'b1;
            end
            if (bus.pop && empty) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    tl_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rd_clr  (flush),
        .wr_en   (push_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.data_in),
        .rd_en   (pop_acc),
        .rd_addr (rd_ptr_q),
        .rd_data (bus.data_out)
    );

    assign bus.valid_out     = valid_q;
    assign bus.count         = count_q;
    assign bus.empty         = empty;
    assign bus.full          = full;
    // Flags follow the thresholds combinationally so a threshold change
    // is visible in the same cycle.
    assign bus.almost_full   = (sup_threshold != '0) && (count_q >= {1'b0, sup_threshold});
    assign bus.almost_empty  = (count_q <= {1'b0, inf_threshold});
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;

endmodule
